// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from active-low VGA HSync/VSync, checks the
// observed timing against the parameters and declares lock after clean frames.
module vga_sync_decoder #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int V_VISIBLE_AREA = 480,
    parameter int H_TOTAL        = 800,
    parameter int V_TOTAL        = 525,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_PULSE   = 96,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 2,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VGA_HSync,
    input  logic       i_VGA_VSync,
    output logic [9:0] o_H_Counter,
    output logic [9:0] o_V_Counter,
    output logic       o_Active,
    output logic       o_Locked,
    output logic       o_Frame_Start,
    output logic       o_Timing_Error,
    output logic [7:0] o_Error_Count
);

    // state    | meaning
    // UNLOCKED | no trusted timing; waiting for a VSync falling edge
    // ARMED    | counting consecutive clean frames towards lock
    // LOCKED   | timing confirmed; o_Active / o_Frame_Start enabled
    typedef enum logic [1:0] {UNLOCKED, ARMED, LOCKED} lock_state_t;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_LOAD = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [9:0] H_RISE = 10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [9:0] V_LOAD = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE_AREA);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE_AREA);
    localparam logic [7:0] LK     = 8'(LOCK_FRAMES);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
        H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE > H_TOTAL ||
        V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE > V_TOTAL) begin : g_bad_params
        $error("vga_sync_decoder: timing parameters do not fit the 10-bit counters");
    end

    logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [9:0]  h_q, v_q, h_d, v_d, h_free, v_free;
    logic        h_aligned_q, v_aligned_q, h_seen_q;
    logic        h_aligned_d, v_aligned_d, h_seen_d;
    logic        h_fall, h_rise, v_fall, h_end, h_wrap, viol;
    lock_state_t state_q, state_d;
    logic [7:0]  clean_q, clean_d;
    logic        locked_q, active_q, frame_q, err_q;
    logic        locked_d, active_d, frame_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        h_fall = hs_s2_q & ~hs_s1_q;
        h_rise = ~hs_s2_q & hs_s1_q;
        v_fall = vs_s2_q & ~vs_s1_q;
        h_end  = (h_q == H_LAST);
        h_wrap = h_end & ~h_fall;
        h_free = h_end ? 10'd0 : h_q + 10'd1;
        v_free = v_q;
        if (h_wrap) begin
            v_free = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        h_d = h_fall ? H_LOAD : h_free;
        v_d = v_fall ? V_LOAD : v_free;

        h_seen_d = h_seen_q;
        if (h_fall) begin
            h_seen_d = 1'b1;
        end else if (h_wrap) begin
            h_seen_d = 1'b0;
        end
        h_aligned_d = h_aligned_q | h_fall;
        v_aligned_d = v_aligned_q | v_fall;

        // Checks only apply once that axis has been aligned at least once,
        // so the initial acquisition after reset is never a violation.
        viol = (h_aligned_q & h_fall & (h_free != H_LOAD)) |
               (h_aligned_q & h_rise & (h_free != H_RISE)) |
               (h_aligned_q & h_wrap & ~h_seen_q) |
               (v_aligned_q & v_fall & (v_free != V_LOAD));

        state_d = state_q;
        clean_d = clean_q;
        case (state_q)
            UNLOCKED: begin
                if (v_fall && !viol) begin
                    state_d = ARMED;
                    clean_d = 8'd0;
                end
            end
            ARMED: begin
                if (viol) begin
                    state_d = UNLOCKED;
                    clean_d = 8'd0;
                end else if (v_fall) begin
                    clean_d = clean_q + 8'd1;
                    if (clean_q + 8'd1 >= LK) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_d = UNLOCKED;
                    clean_d = 8'd0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                clean_d = 8'd0;
            end
        endcase

        locked_d  = (state_d == LOCKED);
        active_d  = locked_d & (h_d < H_VIS) & (v_d < V_VIS);
        frame_d   = locked_d & (h_d == 10'd0) & (v_d == 10'd0);
        err_cnt_d = (viol && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            hs_s1_q     <= 1'b1;
            hs_s2_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            vs_s2_q     <= 1'b1;
            h_q         <= 10'd0;
            v_q         <= 10'd0;
            h_aligned_q <= 1'b0;
            v_aligned_q <= 1'b0;
            h_seen_q    <= 1'b0;
            state_q     <= UNLOCKED;
            clean_q     <= 8'd0;
            locked_q    <= 1'b0;
            active_q    <= 1'b0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            hs_s1_q     <= i_VGA_HSync;
            hs_s2_q     <= hs_s1_q;
            vs_s1_q     <= i_VGA_VSync;
            vs_s2_q     <= vs_s1_q;
            h_q         <= h_d;
            v_q         <= v_d;
            h_aligned_q <= h_aligned_d;
            v_aligned_q <= v_aligned_d;
            h_seen_q    <= h_seen_d;
            state_q     <= state_d;
            clean_q     <= clean_d;
            locked_q    <= locked_d;
            active_q    <= active_d;
            frame_q     <= frame_d;
            err_q       <= viol;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_H_Counter    = h_q;
    assign o_V_Counter    = v_q;
    assign o_Active       = active_q;
    assign o_Locked       = locked_q;
    assign o_Frame_Start  = frame_q;
    assign o_Timing_Error = err_q;
    assign o_Error_Count  = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken video timing so that
// several frames and a few hundred lines fit in a short run.
module tb_vga_sync_decoder;

    localparam int HV = 16, HFP = 2, HSW = 4, HT = 26;
    localparam int VV = 8,  VFP = 1, VSW = 2, VT = 13;
    localparam int H_LOAD = HV + HFP;
    localparam int H_RISE = HV + HFP + HSW;
    localparam int V_LOAD = VV + VFP;

    logic       clk = 1'b0;
    logic       rst_l, hs, vs;
    logic [9:0] o_h, o_v;
    logic       o_act, o_lock, o_fs, o_err;
    logic [7:0] o_ecnt;

    int n_checks = 0, n_err = 0;
    int sh = 0, sv = 0, line_len = HT, vfall_cnt = 0;
    int err_seen = 0, act_seen = 0, fs_seen = 0;
    logic short_req = 1'b0, pulse_req = 1'b0, pulse_short = 1'b0, hs_stuck = 1'b0;
    logic prev_vs;
    int sv_rec;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_VISIBLE_AREA(HV), .V_VISIBLE_AREA(VV), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSW), .V_FRONT_PORCH(VFP),
        .V_SYNC_PULSE(VSW), .LOCK_FRAMES(2)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_VGA_HSync(hs), .i_VGA_VSync(vs),
        .o_H_Counter(o_h), .o_V_Counter(o_v), .o_Active(o_act), .o_Locked(o_lock),
        .o_Frame_Start(o_fs), .o_Timing_Error(o_err), .o_Error_Count(o_ecnt)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source counters run two positions ahead of where the decoder shows them.
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_err)  err_seen++;
        if (o_act)  act_seen++;
        if (o_fs)   fs_seen++;
        if (sh == line_len - 1) begin
            sh = 0;
            sv = (sv == VT - 1) ? 0 : sv + 1;
            line_len = short_req ? HT - 1 : HT;
            short_req = 1'b0;
            pulse_short = pulse_req;
            pulse_req = 1'b0;
        end else begin
            sh++;
        end
        prev_vs = vs;
        hs = hs_stuck || !(sh >= H_LOAD && sh < H_RISE - (pulse_short ? 1 : 0));
        vs = !(sv >= V_LOAD && sv < V_LOAD + VSW);
        if (prev_vs && !vs) vfall_cnt++;
    endtask

    task automatic wait_pos(input string tag, input int h, input int v);
        int guard = 0;
        while (!(sh == h && (v < 0 || sv == v)) && guard < 2 * HT * VT) begin
            tick();
            guard++;
        end
        if (guard >= 2 * HT * VT) check_eq(tag, 0, 1);
    endtask

    task automatic wait_vfalls(input string tag, input int n);
        int guard = 0;
        while (vfall_cnt < n && guard < 5 * HT * VT) begin
            tick();
            guard++;
        end
        if (guard >= 5 * HT * VT) check_eq(tag, 0, 1);
    endtask

    initial begin
        int guard;
        rst_l = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        repeat (3) tick();
        check_eq("rst_h", int'(o_h), 0);
        check_eq("rst_v", int'(o_v), 0);
        check_eq("rst_act", int'(o_act), 0);
        check_eq("rst_lock", int'(o_lock), 0);
        check_eq("rst_fs", int'(o_fs), 0);
        check_eq("rst_err", int'(o_err), 0);
        check_eq("rst_ecnt", int'(o_ecnt), 0);

        // Acquisition: lock one clock after the third detected VSync fall.
        rst_l = 1'b1;
        vfall_cnt = 0;
        wait_vfalls("lock_timeout", 3);
        tick();
        check_eq("lock_early", int'(o_lock), 0);
        tick();
        check_eq("lock_rise", int'(o_lock), 1);
        check_eq("lock_ecnt", int'(o_ecnt), 0);

        wait_pos("align_timeout", H_LOAD, -1);
        sv_rec = sv;
        tick();
        tick();
        check_eq("align_h", int'(o_h), H_LOAD);
        check_eq("align_v", int'(o_v), sv_rec);

        guard = 0;
        while (!o_fs && guard < 2 * HT * VT) begin
            tick();
            guard++;
        end
        check_eq("fs_found", int'(o_fs), 1);
        check_eq("fs_h", int'(o_h), 0);
        check_eq("fs_v", int'(o_v), 0);
        act_seen = int'(o_act);
        fs_seen = 1;
        err_seen = 0;
        repeat (HT * VT - 1) tick();
        check_eq("frame_active", act_seen, HV * VV);
        check_eq("frame_fs", fs_seen, 1);
        check_eq("frame_err", err_seen, 0);

        // One line short by a clock.
        check_eq("locked_pre", int'(o_lock), 1);
        wait_pos("short_timeout", 5, 3);
        short_req = 1'b1;
        err_seen = 0;
        wait_pos("short_run", 0, 7);
        check_eq("short_pulses", err_seen, 1);
        check_eq("short_ecnt", int'(o_ecnt), 1);
        check_eq("short_unlock", int'(o_lock), 0);
        vfall_cnt = 0;
        wait_vfalls("relock_timeout", 3);
        tick();
        check_eq("relock_early", int'(o_lock), 0);
        tick();
        check_eq("relock", int'(o_lock), 1);
        check_eq("relock_ecnt", int'(o_ecnt), 1);

        // HSync pulse one clock short: rising edge arrives early.
        wait_pos("pulse_timeout", 5, 3);
        pulse_req = 1'b1;
        err_seen = 0;
        wait_pos("pulse_run", 0, 6);
        check_eq("pulse_pulses", err_seen, 1);
        check_eq("pulse_ecnt", int'(o_ecnt), 2);

        // HSync stuck high: one violation per line, counter saturates.
        wait_pos("stuck_timeout", 0, -1);
        hs_stuck = 1'b1;
        hs = 1'b1;
        err_seen = 0;
        repeat (HT + 10) tick();
        check_eq("stuck_pulses", err_seen, 1);
        check_eq("stuck_ecnt", int'(o_ecnt), 3);
        repeat (300 * HT) tick();
        check_eq("sat_ecnt", int'(o_ecnt), 255);
        repeat (HT) tick();
        check_eq("sat_hold", int'(o_ecnt), 255);

        // Reset mid-line while HSync is low.
        hs_stuck = 1'b0;
        wait_pos("mrst_timeout", H_LOAD + 1, -1);
        check_eq("mrst_hs_low", int'(hs), 0);
        rst_l = 1'b0;
        tick();
        check_eq("mrst_h", int'(o_h), 0);
        check_eq("mrst_v", int'(o_v), 0);
        check_eq("mrst_act", int'(o_act), 0);
        check_eq("mrst_lock", int'(o_lock), 0);
        check_eq("mrst_fs", int'(o_fs), 0);
        check_eq("mrst_err", int'(o_err), 0);
        check_eq("mrst_ecnt", int'(o_ecnt), 0);
        tick();
        rst_l = 1'b1;
        tick();
        check_eq("rel_err", int'(o_err), 0);
        check_eq("rel_h", int'(o_h), 1);
        check_eq("rel_ecnt", int'(o_ecnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: VGA_Sync_Decoder

Interface
REQ-001 Parameter H_VISIBLE_AREA, default 640, visible pixels per line.
REQ-002 Parameter V_VISIBLE_AREA, default 480, visible lines per frame.
REQ-003 Parameter H_TOTAL, default 800, clocks per line.
REQ-004 Parameter V_TOTAL, default 525, lines per frame.
REQ-005 Parameters H_FRONT_PORCH 16, H_SYNC_PULSE 96, V_FRONT_PORCH 10, V_SYNC_PULSE 2, porch/pulse widths in clocks (H) or lines (V).
REQ-006 Parameter LOCK_FRAMES, default 2, clean frames required for lock.
REQ-007 i_Clk  input  1  the single clock; all logic on rising edge.
REQ-008 i_Rst_L  input  1  reset, synchronous, active-low.
REQ-009 i_VGA_HSync / i_VGA_VSync  input  1 each  active-low sync pulses from a VGA source.
REQ-010 o_H_Counter  output  10  recovered horizontal position.
REQ-011 o_V_Counter  output  10  recovered vertical position.
REQ-012 o_Active  output  1  recovered position is inside the visible area and decoder is locked.
REQ-013 o_Locked  output  1  timing matches parameters for LOCK_FRAMES consecutive frames.
REQ-014 o_Frame_Start  output  1  one-cycle pulse at position (0,0) while locked.
REQ-015 o_Timing_Error  output  1  one-cycle pulse per detected timing violation.
REQ-016 o_Error_Count  output  8  saturating count of violations since reset.

Function
REQ-017 Sync inputs SHALL pass through two registers; an edge SHALL be detected by comparing the stages; the fixed latency from input sample to counter alignment SHALL be 2 clocks.
REQ-018 o_H_Counter SHALL increment every clock and wrap H_TOTAL-1 -> 0; o_V_Counter SHALL increment on each H wrap and wrap V_TOTAL-1 -> 0.
REQ-019 On an HSync falling edge, o_H_Counter SHALL equal H_VISIBLE_AREA+H_FRONT_PORCH (656) two clocks after the first low HSync sample; a free-running value other than this SHALL be overwritten with it and SHALL raise a violation.
REQ-020 On a VSync falling edge, o_V_Counter SHALL be loaded with V_VISIBLE_AREA+V_FRONT_PORCH (490); on a simultaneous H wrap, the load SHALL win; a mismatch against the free-running value SHALL raise a violation.
REQ-021 On an HSync rising edge at an aligned position other than H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE (752), the block SHALL raise a violation.
REQ-022 If o_H_Counter wraps with no HSync falling edge seen during that line, the block SHALL raise a violation.
REQ-023 Each violation SHALL cause o_Timing_Error to pulse high for exactly 1 clock; multiple violations in the same clock SHALL count once.
REQ-024 o_Error_Count SHALL increment on each o_Timing_Error pulse and SHALL saturate at 255.
REQ-025 Lock FSM states: UNLOCKED, ARMED, LOCKED; reset state UNLOCKED.
REQ-026 Transition UNLOCKED->ARMED on the first VSync falling edge; the clean-frame counter SHALL be cleared.
REQ-027 In ARMED, each VSync falling edge with no violation since the previous one SHALL increment the clean-frame counter; on reaching LOCK_FRAMES the FSM SHALL enter LOCKED.
REQ-028 Any violation in ARMED or LOCKED SHALL return the FSM to UNLOCKED and clear the counter; a violation on the same clock as a VSync edge SHALL take priority.
REQ-029 o_Locked SHALL be high only in LOCKED, registered, asserted the clock after the qualifying VSync edge.
REQ-030 o_Active SHALL be o_Locked AND H<H_VISIBLE_AREA AND V<V_VISIBLE_AREA, aligned to the same clock as the counters.
REQ-031 o_Frame_Start SHALL pulse when o_Locked and o_H_Counter==0 and o_V_Counter==0.

Reset
REQ-032 While i_Rst_L is low at a clock edge, the block SHALL set both counters to 0, o_Active/o_Locked/o_Frame_Start/o_Timing_Error to 0, o_Error_Count to 0, and the FSM to UNLOCKED.
REQ-033 Reset SHALL load both sync pipeline stages to 1 so that no edge is detected in the first clock after release, regardless of input level.
REQ-034 Reset asserted mid-frame SHALL take effect on the next clock edge with no residual violation pulse after release.

Verification
REQ-035 Release reset, drive nominal 640x480 timing -> o_Locked rises 1 clock after the 3rd VSync falling edge; o_Error_Count stays 0.
REQ-036 Once locked, first low HSync sample at cycle t -> o_H_Counter==656 at t+2; o_Active high for exactly 640x480 positions per frame; one o_Frame_Start per frame.
REQ-037 Locked, shorten one line to 799 clocks -> one o_Timing_Error pulse, o_Error_Count=1, o_Locked low; o_Locked high again after 3 further clean VSync edges.
REQ-038 HSync pulse of 95 clocks -> violation on the rising edge, o_Error_Count increments by 1.
REQ-039 HSync held high for one full line -> violation at the H wrap; hold sync stuck for more than 255 lines -> o_Error_Count==255 and held.
REQ-040 Assert i_Rst_L low mid-frame with HSync low -> all outputs 0 next clock; no o_Timing_Error in the first clock after release.
